// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812B serializer.
// The defaults assume a 12 MHz system clock.
package ws2812_pkg;

    // Serializer phases: power-up latch, waiting for a word,
    // shifting a word out, and the end-of-frame latch period.
    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        IDLE    = 2'd1,
        SEND    = 2'd2,
        LATCH   = 2'd3
    } state_t;

    // One GRB pixel word: [23:16]=G, [15:8]=R, [7:0]=B.
    localparam int PIX_W = 24;

    // Default waveform timing in clk cycles at 12 MHz.
    localparam int DEF_T0H        = 4;     // ~0.33 us high for a '0'
    localparam int DEF_T1H        = 8;     // ~0.67 us high for a '1'
    localparam int DEF_TBIT       = 15;    // 1.25 us per bit
    localparam int DEF_TRESET     = 3600;  // 300 us low to latch
    localparam int DEF_NUM_PIXELS = 64;    // 8x8 matrix

endpackage : ws2812_pkg

// File: rtl/ws2812_serializer.sv
// WS2812B single-wire serializer: takes GRB words over valid/ready,
// drives the LED data pin, inserts the latch low period after each
// frame and pulses frame_done when the latch period has elapsed.
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TRESET     = DEF_TRESET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    // Counter widths sized to the parameters.
    localparam int CYC_W = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int PIX_CNT_W = $clog2(NUM_PIXELS + 1);
    localparam int TMR_W = $clog2(TRESET + 1);

    // Terminal counts and thresholds in counter width.
    localparam logic [CYC_W-1:0]     CYC_LAST = CYC_W'(TBIT - 1);
    localparam logic [CYC_W-1:0]     T0H_C    = CYC_W'(T0H);
    localparam logic [CYC_W-1:0]     T1H_C    = CYC_W'(T1H);
    localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(NUM_PIXELS - 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TRESET - 1);
    localparam logic [4:0]           MSB_IDX  = 5'(PIX_W - 1);

    state_t                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_cnt_q, cyc_cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;       // startup / latch / underrun timer
    logic [PIX_W-1:0]       shreg_q, shreg_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic                   bit_last;
    logic                   word_last;
    logic                   frame_last;
    logic                   accept;

    // Handshake: ready while idle, or in the final cycle of a word that
    // is not the last of the frame so the next word follows with no gap.
    always_comb begin
        bit_last    = (cyc_cnt_q == CYC_LAST);
        word_last   = bit_last && (bit_cnt_q == 5'd0);
        frame_last  = (pix_cnt_q == PIX_LAST);
        pixel_ready = (state_q == IDLE) ||
                      ((state_q == SEND) && word_last && !frame_last);
        accept      = pixel_valid && pixel_ready;
    end

    // Next-state and counter logic for the four phases.
    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        tmr_d        = tmr_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;

        case (state_q)
            STARTUP: begin
                // Hold the line low long enough for the LEDs to reset.
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            IDLE: begin
                if (accept) begin
                    shreg_d   = pixel_data;
                    bit_cnt_d = MSB_IDX;
                    cyc_cnt_d = '0;
                    tmr_d     = '0;
                    state_d   = SEND;
                end else if (pix_cnt_q != '0) begin
                    // A partial frame left idle this long has already been
                    // latched by the LEDs, so the next word restarts a frame.
                    if (tmr_q == TMR_LAST) begin
                        pix_cnt_d = '0;
                        tmr_d     = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end

            SEND: begin
                if (!bit_last) begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end else begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q != 5'd0) begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else if (frame_last) begin
                        pix_cnt_d = '0;
                        tmr_d     = '0;
                        state_d   = LATCH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (accept) begin
                            shreg_d   = pixel_data;
                            bit_cnt_d = MSB_IDX;
                        end else begin
                            tmr_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end

            LATCH: begin
                if (tmr_q == TMR_LAST) begin
                    tmr_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                tmr_d   = '0;
                state_d = STARTUP;
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered
    // versions line up exactly with the phase and bit counter they describe.
    always_comb begin
        dout_d = (state_d == SEND) &&
                 (cyc_cnt_d < (shreg_d[PIX_W-1] ? T1H_C : T0H_C));
        busy_d = (state_d == SEND) || (state_d == LATCH);
    end

    // State and output registers; reset forces the data line low at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STARTUP;
            cyc_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            tmr_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            tmr_q        <= tmr_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule : ws2812_serializer

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer with short latch timing (TRESET=100) and
// a two-pixel frame. A queue-based waveform model predicts every output
// each cycle; directed steps add hand-computed literal expectations.
module tb_ws2812_serializer;

    localparam int NP = 2;
    localparam int TR = 100;
    localparam int T0 = 4;
    localparam int T1 = 8;
    localparam int TB = 15;

    localparam int PH_START = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_SEND  = 2;
    localparam int PH_LATCH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        dout;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    ws2812_serializer #(
        .NUM_PIXELS (NP),
        .T0H        (T0),
        .T1H        (T1),
        .TBIT       (TB),
        .TRESET     (TR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The expected line level for a word is built up front as a list of
    // per-cycle levels; while sending, the head of that list is the level.
    int m_phase;
    int m_timer;
    int m_idle;
    int m_pix;
    bit m_fd;
    bit m_wave[$];

    function automatic void load_wave(input logic [23:0] w);
        m_wave.delete();
        for (int b = 23; b >= 0; b--)
            for (int c = 0; c < TB; c++)
                m_wave.push_back(c < (w[b] ? T1 : T0));
    endfunction

    function automatic bit model_ready();
        return (m_phase == PH_IDLE) ||
               (m_phase == PH_SEND && m_wave.size() == 1 && m_pix != NP - 1);
    endfunction

    function automatic bit model_dout();
        if (m_phase == PH_SEND && m_wave.size() > 0) return m_wave[0];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = PH_START;
        m_timer = TR;
        m_idle  = 0;
        m_pix   = 0;
        m_fd    = 1'b0;
        m_wave.delete();
    endtask

    task automatic model_step();
        bit take;
        take = model_ready() && (pixel_valid === 1'b1);
        m_fd = 1'b0;
        case (m_phase)
            PH_START: begin
                m_timer--;
                if (m_timer == 0) m_phase = PH_IDLE;
            end
            PH_IDLE: begin
                if (take) begin
                    load_wave(pixel_data);
                    m_phase = PH_SEND;
                    m_idle  = 0;
                end else if (m_pix != 0) begin
                    m_idle++;
                    if (m_idle == TR) begin
                        m_pix  = 0;
                        m_idle = 0;
                    end
                end
            end
            PH_SEND: begin
                if (m_wave.size() > 1) begin
                    void'(m_wave.pop_front());
                end else if (m_pix == NP - 1) begin
                    m_wave.delete();
                    m_phase = PH_LATCH;
                    m_timer = TR;
                    m_pix   = 0;
                end else begin
                    m_pix++;
                    if (take) begin
                        load_wave(pixel_data);
                    end else begin
                        m_wave.delete();
                        m_phase = PH_IDLE;
                        m_idle  = 0;
                    end
                end
            end
            default: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_phase = PH_IDLE;
                    m_fd    = 1'b1;
                    m_idle  = 0;
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout",        dout,        model_dout());
            check("pixel_ready", pixel_ready, model_ready());
            check("busy",        busy,        (m_phase == PH_SEND || m_phase == PH_LATCH));
            check("frame_done",  frame_done,  m_fd);
        end
    end

    // Running totals and one log line per transaction.
    int hi_cnt = 0;
    int busy_cnt = 0;
    int fd_cnt = 0;

    always @(negedge clk) begin
        if (dout === 1'b1)       hi_cnt   <= hi_cnt + 1;
        if (busy === 1'b1)       busy_cnt <= busy_cnt + 1;
        if (frame_done === 1'b1) fd_cnt   <= fd_cnt + 1;
        if (rst === 1'b0 && pixel_valid === 1'b1 && pixel_ready === 1'b1)
            $display("accept pixel %06h at t=%0t", pixel_data, $time);
        if (frame_done === 1'b1)
            $display("frame_done at t=%0t", $time);
    end

    // ---------------- stimulus helpers ----------------
    // Present a word and return 2 time units after the edge that took it.
    task automatic put(input logic [23:0] w);
        int   n;
        logic r;
        pixel_data  = w;
        pixel_valid = 1'b1;
        n = 0;
        r = 1'b0;
        do begin
            @(negedge clk);
            r = pixel_ready;
            @(posedge clk);
            n++;
        end while (r !== 1'b1 && n < 3000);
        #2;
        check("put_accepted", r, 1);
    endtask

    task automatic idle_in();
        pixel_valid = 1'b0;
        pixel_data  = 24'($urandom);
    endtask

    task automatic wait_fd(input int limit, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < limit) begin
            @(negedge clk);
            got = (frame_done === 1'b1);
            n++;
        end
        check("frame_done_seen", got, 1);
    endtask

    task automatic startup_len(output int c);
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            if (pixel_ready === 1'b1) break;
            c++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, want completion by t=600000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          n;
        int          hi0;
        int          bz0;
        int          fd0;
        logic [31:0] cap;

        rst         = 1'b1;
        pixel_valid = 1'b0;
        pixel_data  = 24'h0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        check("reset_dout",  dout, 0);
        check("reset_ready", pixel_ready, 0);
        check("reset_busy",  busy, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // 1: startup hold is exactly TRESET cycles with no frame_done.
        startup_len(c);
        check("startup_len", c, 100);
        check("startup_no_fd", fd_cnt, 0);
        @(posedge clk); #2;

        // 2: single word A50000, waveform shape and length.
        hi0 = hi_cnt; bz0 = busy_cnt; fd0 = fd_cnt;
        put(24'hA50000);
        idle_in();
        cap = '0;
        #3 cap[0] = dout;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk); #3;
            cap[k] = dout;
        end
        check("a5_first_two_bits", cap, 32'h000780FF);
        repeat (330) @(posedge clk);
        #3;
        check("a5_last_cycle_ready", pixel_ready, 1);
        check("a5_last_cycle_busy",  busy, 1);
        @(posedge clk); #3;
        check("a5_after_busy", busy, 0);
        repeat (240) @(posedge clk);
        #2;
        check("a5_high_cycles", hi_cnt - hi0, 112);
        check("a5_busy_cycles", busy_cnt - bz0, 360);
        check("a5_no_fd", fd_cnt - fd0, 0);

        // 3: back-to-back FFFFFF, 000001 complete a frame.
        hi0 = hi_cnt; bz0 = busy_cnt; fd0 = fd_cnt;
        put(24'hFFFFFF);
        put(24'h000001);
        idle_in();
        wait_fd(2000, n);
        check("t3_ready_at_fd", pixel_ready, 1);
        repeat (20) @(posedge clk);
        #2;
        check("t3_fd_count", fd_cnt - fd0, 1);
        check("t3_busy_cycles", busy_cnt - bz0, 820);
        check("t3_high_cycles", hi_cnt - hi0, 292);

        // 4: 20-cycle upstream stall between pixels, frame still completes.
        hi0 = hi_cnt; bz0 = busy_cnt; fd0 = fd_cnt;
        put(24'h123456);
        idle_in();
        repeat (379) @(posedge clk);
        #2;
        put(24'h00FF00);
        idle_in();
        wait_fd(1000, n);
        check("t4_p1_to_fd", n, 461);
        repeat (5) @(posedge clk);
        #2;
        check("t4_fd_count", fd_cnt - fd0, 1);
        check("t4_busy_cycles", busy_cnt - bz0, 820);
        check("t4_high_cycles", hi_cnt - hi0, 260);

        // 5: underrun discards the partial frame without frame_done.
        bz0 = busy_cnt; fd0 = fd_cnt;
        put(24'h0F0F0F);
        idle_in();
        repeat (510) @(posedge clk);
        #2;
        check("t5_underrun_no_fd", fd_cnt - fd0, 0);
        put(24'hC00003);
        put(24'h3C0000);
        idle_in();
        wait_fd(1200, n);
        repeat (3) @(posedge clk);
        #2;
        check("t5_fd_count", fd_cnt - fd0, 1);
        check("t5_busy_cycles", busy_cnt - bz0, 1180);

        // 6: reset in the middle of bit 10 of pixel 1.
        put(24'hAAAAAA);
        put(24'hFFFFFF);
        idle_in();
        repeat (196) @(posedge clk);
        #3;
        check("t6_dout_before_rst", dout, 1);
        fd0 = fd_cnt;
        rst = 1'b1;
        #1;
        check("t6_dout_in_rst",  dout, 0);
        check("t6_busy_in_rst",  busy, 0);
        check("t6_ready_in_rst", pixel_ready, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        startup_len(c);
        check("t6_startup_len", c, 100);
        check("t6_no_fd", fd_cnt - fd0, 0);
        @(posedge clk); #2;
        hi0 = hi_cnt; fd0 = fd_cnt;
        put(24'h800001);
        put(24'h00FF00);
        idle_in();
        wait_fd(1200, n);
        repeat (3) @(posedge clk);
        #2;
        check("t6_fd_count", fd_cnt - fd0, 1);
        check("t6_high_cycles", hi_cnt - hi0, 232);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ws2812_serializer

// File: doc/ws2812_serializer.md
Name: ws2812_serializer

Overview:
- Final output stage of the Game of Life LED path.
- Consumes 24-bit GRB pixel words from the frame-scan logic over a valid/ready handshake.
- Emits the single-wire WS2812B waveform that drives the matrix data pin (_48b in top).
- Inserts the latch/reset low period after each complete frame and reports frame completion upstream.

Parameters:
- NUM_PIXELS, 64: pixels per frame (8x8 matrix).
- T0H, 4: high cycles for a '0' bit (12 MHz clk, about 0.33 us).
- T1H, 8: high cycles for a '1' bit (about 0.67 us).
- TBIT, 15: total cycles per bit (1.25 us); T0H < T1H < TBIT.
- TRESET, 3600: low cycles for latch (300 us).

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  asynchronous, active-high reset.
- pixel_data  in  24  GRB word; [23:16]=G, [15:8]=R, [7:0]=B.
- pixel_valid  in  1  upstream presents pixel_data.
- pixel_ready  out  1  serializer accepts a word this cycle when pixel_valid=1.
- dout  out  1  WS2812 serial data.
- busy  out  1  high in SEND or LATCH.
- frame_done  out  1  one-cycle pulse after latch completes.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset: state=STARTUP, counters=0, dout=0, frame_done=0, pixel_ready=0, busy=0.
- STARTUP: dout=0, ready=0.
  - Counts TRESET cycles, then goes to IDLE.
  - No frame_done pulse on this exit.
- IDLE: ready=1, dout=0, busy=0.
  - On valid&ready: load shift register with pixel_data, bit_cnt=23, cyc_cnt=0, go to SEND.
- SEND: dout = (cyc_cnt < (shreg[23] ? T1H : T0H)).
  - cyc_cnt counts 0..TBIT-1. On TBIT-1: wrap to 0, shift left, decrement bit_cnt. Bits go MSB first.
  - Last cycle of bit 0 with pix_cnt != NUM_PIXELS-1: ready=1 combinationally.
    - If valid: load the new word and start bit 23 on the next cycle (zero-gap streaming). pix_cnt++.
    - Otherwise: pix_cnt++ and go to IDLE.
  - Last cycle of bit 0 with pix_cnt == NUM_PIXELS-1: ready=0. Go to LATCH, pix_cnt=0.
- LATCH: dout=0, ready=0, busy=1.
  - Counts TRESET cycles, then pulses frame_done for one cycle (coincident with the IDLE entry cycle) and goes to IDLE.
- Underrun: in IDLE with pix_cnt != 0, an idle counter runs.
  - After TRESET cycles the LEDs have latched a partial frame: pix_cnt=0, no frame_done.
  - The next word starts a new frame.
  - Idle counter clears on every accept.
- pixel_data is sampled only on the accept cycle; later changes have no effect.
- Reset mid-frame or mid-bit: dout drops to 0 asynchronously and the block re-enters STARTUP.
- Counter widths: cyc_cnt $clog2(TBIT), bit_cnt 5, pix_cnt $clog2(NUM_PIXELS+1), latch/idle counter $clog2(TRESET+1).
- All outputs except pixel_ready are registered.

Decomposition:
- Shared package ws2812_pkg:
  - state enum {STARTUP, IDLE, SEND, LATCH}
  - default timing constants for 12 MHz (T0H, T1H, TBIT, TRESET)
  - pixel width constant PIX_W=24
- Single module, no sub-module. The bit-timing counter and latch counter are small enough to stay inline.

Test Plan (sim parameters: TRESET=100, NUM_PIXELS=2):
1. Reset release: rst high 3 cycles, then low → dout=0, pixel_ready=0 for 100 cycles, then pixel_ready=1; frame_done stays 0.
2. Single word 24'hA50000, valid held → bit 23 ('1') high 8 cycles/low 7; bit 22 ('0') high 4/low 11; 360 cycles total; pixel_ready=1 in its last cycle.
3. Back-to-back 24'hFFFFFF then 24'h000001 with valid held → no gap between pixels (720 contiguous bit cycles); then dout low 100 cycles, one frame_done pulse, then pixel_ready=1.
4. Upstream stall 20 cycles between pixel 0 and pixel 1 → dout low 20 cycles, no latch, pix_cnt preserved; frame_done after pixel 1 plus 100 cycles.
5. Underrun: send one pixel, withhold valid 150 cycles → pix_cnt returns to 0, no frame_done; next two pixels form a complete frame with one frame_done.
6. rst asserted at bit 10 of pixel 1 → dout=0 immediately; after release 100-cycle STARTUP, no frame_done; the next frame serializes correctly from pixel 0.
